// File: rtl/ifbuf_pkg.sv
// Shared geometry, line type and read-mode encoding for the ifmap ping-pong line buffer.
package ifbuf_pkg;
  localparam int DW    = 32;
  localparam int POY   = 3;
  localparam int BUFW  = 32;
  localparam int NBANK = 3;
  localparam int NROW  = 4;
  localparam int DEPTH = 16;
  localparam int DEPW  = $clog2(DEPTH);
  localparam int BANKW = 2;
  localparam int ROWW  = 2;
  localparam int COLW  = 28;

  typedef enum logic [1:0] {
    RP_IDLE  = 2'd0,
    RP_WIN   = 2'd1,
    RP_BCAST = 2'd2,
    RP_RSV   = 2'd3
  } rpsel_e;

  typedef logic [BUFW-1:0][DW-1:0] line_t;

  function automatic logic bank_ok(logic [BANKW-1:0] b);
    return int'(b) < NBANK;
  endfunction

  function automatic logic row_ok(logic [ROWW-1:0] r);
    return int'(r) < NROW;
  endfunction
endpackage

// File: rtl/ifbuf_half.sv
// One half of the ping-pong store: single write port, POY registered read ports sharing bank/col.
module ifbuf_half
  import ifbuf_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_we,
  input  logic [BANKW-1:0]                 i_wr_bank,
  input  logic [ROWW-1:0]                  i_wr_row,
  input  logic [DEPW-1:0]                  i_wr_col,
  input  line_t                            i_wr_data,
  input  logic                             i_re,
  input  logic [BANKW-1:0]                 i_rd_bank,
  input  logic [POY-1:0][ROWW-1:0]         i_rd_row,
  input  logic [DEPW-1:0]                  i_rd_col,
  output logic [POY-1:0][BUFW-1:0][DW-1:0] o_rd_data
);
  line_t r_mem [NBANK][NROW][DEPTH];
  logic [POY-1:0][BUFW-1:0][DW-1:0] r_rd_data;

  // Storage is deliberately not reset; only the read registers are.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_wr_bank][i_wr_row][i_wr_col] <= i_wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data <= '0;
    end else if (i_re) begin
      for (int y = 0; y < POY; y++) r_rd_data[y] <= r_mem[i_rd_bank][i_rd_row[y]][i_rd_col];
    end
  end

  assign o_rd_data = r_rd_data;
endmodule

// File: rtl/ifmap_pingpong_buf.sv
// Double-buffered ifmap line store: loader fills one half while the router reads the other.
// Optional sticky protocol checker enabled with `define IFBUF_ERRCHK_EN.
module ifmap_pingpong_buf
  import ifbuf_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             wr_valid,
  output logic                             wr_ready,
  input  logic [BANKW-1:0]                 wr_bank,
  input  logic [ROWW-1:0]                  wr_row,
  input  logic [DEPW-1:0]                  wr_col,
  input  line_t                            wr_data,
  input  logic                             wr_last,
  input  logic [1:0]                       rpsel,
  input  logic [BANKW-1:0]                 bank,
  input  logic [ROWW-1:0]                  row,
  input  logic [COLW-1:0]                  col,
  input  logic                             blkend,
  output logic [POY-1:0][BUFW-1:0][DW-1:0] data,
  output logic                             buf_rdy,
  output logic                             buf_err
);
  // Write handshake: a beat transfers on an edge where wr_valid && wr_ready;
  // wr_ready depends only on registered state, never on wr_valid.
  logic [1:0] r_full;
  logic       r_wr_ptr, r_rd_ptr, r_sel, r_zero;
  logic [1:0] w_full_nxt;
  rpsel_e     w_rpsel;
  logic       w_wr_fire, w_wr_ok, w_commit, w_retire, w_rd_act, w_rd_ok, w_rd_en;
  logic [POY-1:0][ROWW-1:0] w_rd_row;
  logic [POY-1:0][BUFW-1:0][DW-1:0] w_h_data [2];
  logic       w_unused_col;

  assign w_rpsel      = rpsel_e'(rpsel);
  assign wr_ready     = !r_full[r_wr_ptr];
  assign buf_rdy      = r_full[r_rd_ptr];
  assign w_wr_fire    = wr_valid & wr_ready;
  assign w_wr_ok      = bank_ok(wr_bank) & row_ok(wr_row);
  assign w_commit     = w_wr_fire & wr_last;
  assign w_retire     = blkend & buf_rdy;
  assign w_rd_act     = (w_rpsel == RP_WIN) || (w_rpsel == RP_BCAST);
  assign w_rd_ok      = buf_rdy & bank_ok(bank);
  assign w_rd_en      = w_rd_act & w_rd_ok;
  assign w_unused_col = ^col[COLW-1:DEPW];

  // Commit and retire never target the same half: the write half is empty, the read half full.
  always_comb begin
    w_full_nxt = r_full;
    if (w_commit) w_full_nxt[r_wr_ptr] = 1'b1;
    if (w_retire) w_full_nxt[r_rd_ptr] = 1'b0;
  end

  always_comb begin
    w_rd_row = '0;
    for (int y = 0; y < POY; y++) begin
      w_rd_row[y] = (w_rpsel == RP_WIN) ? ROWW'((int'(row) + y) % NROW) : row;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full   <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_sel    <= 1'b0;
      r_zero   <= 1'b1;
    end else begin
      r_full <= w_full_nxt;
      if (w_commit) r_wr_ptr <= ~r_wr_ptr;
      if (w_retire) r_rd_ptr <= ~r_rd_ptr;
      // Idle modes leave both the select and the zero flag alone so data holds.
      if (w_rd_act) begin
        r_zero <= !w_rd_ok;
        if (w_rd_ok) r_sel <= r_rd_ptr;
      end
    end
  end

  for (genvar h = 0; h < 2; h++) begin : g_half
    ifbuf_half u_half (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_we      (w_wr_fire & w_wr_ok & (r_wr_ptr == 1'(h))),
      .i_wr_bank (wr_bank),
      .i_wr_row  (wr_row),
      .i_wr_col  (wr_col),
      .i_wr_data (wr_data),
      .i_re      (w_rd_en & (r_rd_ptr == 1'(h))),
      .i_rd_bank (bank),
      .i_rd_row  (w_rd_row),
      .i_rd_col  (col[DEPW-1:0]),
      .o_rd_data (w_h_data[h])
    );
  end

  assign data = r_zero ? '0 : w_h_data[r_sel];

`ifdef IFBUF_ERRCHK_EN
  logic r_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if ((blkend & !buf_rdy) | (wr_valid & !w_wr_ok) | (w_rd_act & !buf_rdy)) begin
      r_err <= 1'b1;
    end
  end
  assign buf_err = r_err;
`else
  assign buf_err = 1'b0;
`endif
endmodule

// File: tb/tb_ifmap_pingpong_buf.sv
// Bench for ifmap_pingpong_buf: directed fills/reads, read data checked through an expected queue.
module tb_ifmap_pingpong_buf;
  import ifbuf_pkg::*;

  localparam int W = POY * BUFW * DW;
  typedef logic [POY-1:0][BUFW-1:0][DW-1:0] blk_t;
`ifdef IFBUF_ERRCHK_EN
  localparam logic [31:0] EXP_ERR = 32'd1;
`else
  localparam logic [31:0] EXP_ERR = 32'd0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [BANKW-1:0] wr_bank = '0;
  logic [ROWW-1:0]  wr_row = '0;
  logic [DEPW-1:0]  wr_col = '0;
  line_t            wr_data = '0;
  logic             wr_last = 1'b0;
  logic [1:0]       rpsel = 2'd0;
  logic [BANKW-1:0] bank = '0;
  logic [ROWW-1:0]  row = '0;
  logic [COLW-1:0]  col = '0;
  logic             blkend = 1'b0;
  blk_t             data;
  logic             buf_rdy;
  logic             buf_err;

  always #5 clk = ~clk;

  ifmap_pingpong_buf dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_bank  (wr_bank),
    .wr_row   (wr_row),
    .wr_col   (wr_col),
    .wr_data  (wr_data),
    .wr_last  (wr_last),
    .rpsel    (rpsel),
    .bank     (bank),
    .row      (row),
    .col      (col),
    .blkend   (blkend),
    .data     (data),
    .buf_rdy  (buf_rdy),
    .buf_err  (buf_err)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic chk_flag  = 1'b0;
  logic chk_stage = 1'b0;

  // Data is due one edge after the read address; flag that edge for the monitor.
  always @(posedge clk) chk_stage <= chk_flag;

  blk_t mon_e;
  bit   mon_found;
  always @(negedge clk) begin
    if (chk_stage) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_underflow: data arrived with no expected entry");
      end else begin
        mon_e = exp_q.pop_front();
        if (data !== mon_e) begin
          n_fail++;
          mon_found = 1'b0;
          for (int y = 0; y < POY; y++)
            for (int k = 0; k < BUFW; k++)
              if (!mon_found && data[y][k] !== mon_e[y][k]) begin
                mon_found = 1'b1;
                $display("FAIL rd_data y=%0d k=%0d: got %h expected %h", y, k, data[y][k], mon_e[y][k]);
              end
        end
      end
    end
  end

  // ---------------- helpers / drivers ----------------
  function automatic line_t mk_line(int f, int b, int r, int c);
    line_t l;
    for (int k = 0; k < BUFW; k++) l[k] = {8'(f), 4'(b), 4'(r), 8'(c), 8'(k)};
    return l;
  endfunction

  function automatic blk_t blk3(line_t l0, line_t l1, line_t l2);
    blk_t x;
    x[0] = l0;
    x[1] = l1;
    x[2] = l2;
    return x;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(logic [1:0] sel, int b, int r, int c, blk_t e);
    rpsel    = sel;
    bank     = 2'(b);
    row      = 2'(r);
    col      = 28'(c);
    chk_flag = 1'b1;
    exp_q.push_back(e);
    step();
    rpsel    = 2'd0;
    chk_flag = 1'b0;
  endtask

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!wr_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!wr_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL wr_ready_timeout: got 0 expected 1");
    end
  endtask

  // 48 beats: banks 0..2, rows 0..3, cols {0,5,10,15}; wr_last (and optionally blkend) on the 48th.
  task automatic fill(int f, bit blk_on_last);
    int n = 0;
    for (int b = 0; b < NBANK; b++)
      for (int r = 0; r < NROW; r++)
        for (int ci = 0; ci < 4; ci++) begin
          n++;
          wr_valid = 1'b1;
          wr_bank  = 2'(b);
          wr_row   = 2'(r);
          wr_col   = DEPW'(ci * 5);
          wr_data  = mk_line(f, b, r, ci * 5);
          wr_last  = (n == 48);
          blkend   = blk_on_last && (n == 48);
          wait_ready();
          step();
        end
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    blkend   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    wr_valid = 1'b1;
    wr_last  = 1'b1;
    wr_data  = mk_line(9, 0, 0, 0);
    repeat (3) step();
    rst_n    = 1'b1;
    wr_valid = 1'b0;
    wr_last  = 1'b0;
    rd(2'd0, 0, 0, 0, '0);
    @(negedge clk);
    chk("rst_wr_ready", 32'(wr_ready), 32'd1);
    chk("rst_buf_rdy", 32'(buf_rdy), 32'd0);
    chk("rst_buf_err", 32'(buf_err), 32'd0);
    step();

    fill(1, 1'b0);
    @(negedge clk);
    chk("fill1_buf_rdy", 32'(buf_rdy), 32'd1);
    chk("fill1_wr_ready", 32'(wr_ready), 32'd1);
    step();
    rd(2'd1, 1, 3, 5, blk3(mk_line(1, 1, 3, 5), mk_line(1, 1, 0, 5), mk_line(1, 1, 1, 5)));
    rd(2'd3, 0, 0, 0, blk3(mk_line(1, 1, 3, 5), mk_line(1, 1, 0, 5), mk_line(1, 1, 1, 5)));
    rd(2'd2, 2, 0, 15, blk3(mk_line(1, 2, 0, 15), mk_line(1, 2, 0, 15), mk_line(1, 2, 0, 15)));
    rd(2'd1, 3, 0, 0, '0);
    rd(2'd1, 0, 2, 10, blk3(mk_line(1, 0, 2, 10), mk_line(1, 0, 3, 10), mk_line(1, 0, 0, 10)));

    fill(2, 1'b0);
    @(negedge clk);
    chk("both_full_wr_ready", 32'(wr_ready), 32'd0);
    chk("both_full_buf_rdy", 32'(buf_rdy), 32'd1);
    step();

    // Third fill's first beat must stall until the read side retires half 0.
    wr_valid = 1'b1;
    wr_bank  = 2'd0;
    wr_row   = 2'd0;
    wr_col   = '0;
    wr_data  = mk_line(3, 0, 0, 0);
    wr_last  = 1'b0;
    rd(2'd1, 1, 3, 5, blk3(mk_line(1, 1, 3, 5), mk_line(1, 1, 0, 5), mk_line(1, 1, 1, 5)));
    @(negedge clk);
    chk("stall_wr_ready_a", 32'(wr_ready), 32'd0);
    step();
    @(negedge clk);
    chk("stall_wr_ready_b", 32'(wr_ready), 32'd0);
    step();
    blkend = 1'b1;
    step();
    blkend = 1'b0;
    @(negedge clk);
    chk("blkend_wr_ready", 32'(wr_ready), 32'd1);
    chk("half1_buf_rdy", 32'(buf_rdy), 32'd1);
    step();
    wr_valid = 1'b0;
    rd(2'd2, 0, 0, 0, blk3(mk_line(2, 0, 0, 0), mk_line(2, 0, 0, 0), mk_line(2, 0, 0, 0)));
    rd(2'd1, 1, 3, 5, blk3(mk_line(2, 1, 3, 5), mk_line(2, 1, 0, 5), mk_line(2, 1, 1, 5)));

    // Last beat of fill 3 lands together with the retire of half 1.
    fill(3, 1'b1);
    @(negedge clk);
    chk("simul_buf_rdy", 32'(buf_rdy), 32'd1);
    chk("simul_wr_ready", 32'(wr_ready), 32'd1);
    step();
    rd(2'd1, 1, 3, 5, blk3(mk_line(3, 1, 3, 5), mk_line(3, 1, 0, 5), mk_line(3, 1, 1, 5)));
    rd(2'd2, 2, 3, 15, blk3(mk_line(3, 2, 3, 15), mk_line(3, 2, 3, 15), mk_line(3, 2, 3, 15)));

    blkend = 1'b1;
    step();
    blkend = 1'b0;
    @(negedge clk);
    chk("empty_buf_rdy", 32'(buf_rdy), 32'd0);
    chk("empty_wr_ready", 32'(wr_ready), 32'd1);
    chk("err_clean", 32'(buf_err), 32'd0);
    step();

    blkend = 1'b1;
    step();
    blkend = 1'b0;
    @(negedge clk);
    chk("blkend_empty_buf_rdy", 32'(buf_rdy), 32'd0);
    chk("blkend_empty_wr_ready", 32'(wr_ready), 32'd1);
    chk("err_blkend_empty", 32'(buf_err), EXP_ERR);
    step();
    rd(2'd1, 1, 3, 5, '0);
    repeat (3) step();
    @(negedge clk);
    chk("err_sticky", 32'(buf_err), EXP_ERR);
    step();

    rst_n = 1'b0;
    #2;
    chk("rst2_buf_err", 32'(buf_err), 32'd0);
    chk("rst2_wr_ready", 32'(wr_ready), 32'd1);
    step();
    rst_n = 1'b1;
    repeat (2) step();
    chk("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
